// File: rtl/udp_packet_builder.sv
// Builds an Ethernet/IPv4/UDP frame: a 42-byte header generated from latched
// request fields, followed by the payload passed straight through from in_data.
module udp_packet_builder #(
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] src_mac,
  input  logic [47:0] dst_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [10:0] payload_len,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        len_err
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t state, state_next;

  logic [47:0] cfg_src_mac, cfg_dst_mac;
  logic [31:0] cfg_src_ip, cfg_dst_ip;
  logic [15:0] cfg_src_port, cfg_dst_port;
  logic [10:0] cfg_len;

  logic [5:0]  hdr_idx;
  logic [10:0] pay_cnt;
  logic [19:0] csum_acc;
  logic [3:0]  csum_idx;

  logic        accept, too_long, hdr_xfer, pay_xfer;
  logic [15:0] total_len, udp_len, csum_word, hdr_checksum, fold2;
  logic [16:0] fold1;
  logic [335:0] hdr_vec;
  logic [8:0]  hdr_bit;
  logic [7:0]  hdr_byte;

  assign accept    = start_valid & start_ready;
  assign too_long  = 32'(payload_len) > MAX_PAYLOAD;
  assign total_len = 16'(cfg_len) + 16'd28;
  assign udp_len   = 16'(cfg_len) + 16'd8;

  // Word 0 (16'h4500) is loaded at accept; words 1..8 follow one per cycle.
  always_comb begin
    csum_word = '0;
    case (csum_idx)
      4'd1:    csum_word = total_len;
      4'd2:    csum_word = 16'h0000;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {IP_TTL, 8'h11};
      4'd5:    csum_word = cfg_src_ip[31:16];
      4'd6:    csum_word = cfg_src_ip[15:0];
      4'd7:    csum_word = cfg_dst_ip[31:16];
      4'd8:    csum_word = cfg_dst_ip[15:0];
      default: csum_word = '0;
    endcase
  end

  // Two folds absorb every carry a 9-word sum can produce.
  assign fold1        = {1'b0, csum_acc[15:0]} + {13'b0, csum_acc[19:16]};
  assign fold2        = fold1[15:0] + {15'b0, fold1[16]};
  assign hdr_checksum = ~fold2;

  assign hdr_vec = {cfg_dst_mac, cfg_src_mac, 16'h0800,
                    16'h4500, total_len, 16'h0000, 16'h4000, IP_TTL, 8'h11,
                    hdr_checksum, cfg_src_ip, cfg_dst_ip,
                    cfg_src_port, cfg_dst_port, udp_len, 16'h0000};
  assign hdr_bit  = 9'd335 - {hdr_idx, 3'b000};
  assign hdr_byte = hdr_vec[hdr_bit -: 8];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    out_last    = 1'b0;
    in_ready    = 1'b0;
    hdr_xfer    = 1'b0;
    pay_xfer    = 1'b0;
    if (reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          start_ready = 1'b1;
          if (start_valid && !too_long) state_next = HEADER;
        end
        HEADER: begin
          out_valid = 1'b1;
          out_data  = hdr_byte;
          out_last  = (hdr_idx == 6'd41) && (cfg_len == 11'd0);
          hdr_xfer  = out_ready;
          if (out_ready && hdr_idx == 6'd41)
            state_next = (cfg_len == 11'd0) ? IDLE : PAYLOAD;
        end
        PAYLOAD: begin
          out_valid = in_valid;
          out_data  = in_data;
          in_ready  = out_ready;
          out_last  = in_valid && (pay_cnt == 11'd1);
          pay_xfer  = in_valid && out_ready;
          if (pay_xfer && pay_cnt == 11'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_src_mac  <= '0;
      cfg_dst_mac  <= '0;
      cfg_src_ip   <= '0;
      cfg_dst_ip   <= '0;
      cfg_src_port <= '0;
      cfg_dst_port <= '0;
      cfg_len      <= '0;
      hdr_idx      <= '0;
      pay_cnt      <= '0;
      csum_acc     <= '0;
      csum_idx     <= '0;
      len_err      <= 1'b0;
    end else begin
      len_err <= accept && too_long;
      if (accept && !too_long) begin
        cfg_src_mac  <= src_mac;
        cfg_dst_mac  <= dst_mac;
        cfg_src_ip   <= src_ip;
        cfg_dst_ip   <= dst_ip;
        cfg_src_port <= src_port;
        cfg_dst_port <= dst_port;
        cfg_len      <= payload_len;
        hdr_idx      <= '0;
        pay_cnt      <= payload_len;
        csum_acc     <= 20'h04500;
        csum_idx     <= 4'd1;
      end else begin
        if (hdr_xfer) hdr_idx <= hdr_idx + 6'd1;
        if (pay_xfer) pay_cnt <= pay_cnt - 11'd1;
        // Runs independently of out_ready, so stalls cannot disturb the sum.
        if (csum_idx != 4'd0 && csum_idx < 4'd9) begin
          csum_acc <= csum_acc + {4'b0, csum_word};
          csum_idx <= csum_idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_packet_builder.sv
// Directed bench for udp_packet_builder: table of frame requests plus hand-written
// sequences for length rejection, the length boundary and mid-frame reset.
module tb_udp_packet_builder;

  localparam logic [47:0] DMAC  = 48'h001122334455;
  localparam logic [47:0] SMAC  = 48'h66778899AABB;
  localparam logic [31:0] SIP   = 32'hC0A80101;
  localparam logic [31:0] DIP   = 32'hC0A80102;
  localparam logic [15:0] SPORT = 16'h1234;
  localparam logic [15:0] DPORT = 16'h5678;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] src_mac, dst_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port;
  logic [10:0] payload_len;
  logic        start_valid, start_ready;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;
  logic        len_err;

  udp_packet_builder #(.IP_TTL(8'd64), .MAX_PAYLOAD(1472)) dut (
    .clk(clk), .reset(reset),
    .src_mac(src_mac), .dst_mac(dst_mac), .src_ip(src_ip), .dst_ip(dst_ip),
    .src_port(src_port), .dst_port(dst_port), .payload_len(payload_len),
    .start_valid(start_valid), .start_ready(start_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          len;
    logic [31:0] pl;     // payload bytes, first byte most significant
    logic [15:0] csum;   // hand-computed IP header checksum
    bit          stall;  // random out_ready
    bit          gap;    // random in_valid gaps
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int len);
    dst_mac     = DMAC;
    src_mac     = SMAC;
    src_ip      = SIP;
    dst_ip      = DIP;
    src_port    = SPORT;
    dst_port    = DPORT;
    payload_len = 11'(len);
  endtask

  task automatic request(input int len);
    int t;
    t = 0;
    @(negedge clk);
    set_cfg(len);
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    start_valid = 1'b1;
    #1;
    while (!start_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("start_ready_on_request", start_ready, 1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_d[$];
    bit          got_l[$];
    logic [7:0]  pb[4];
    logic [31:0] tmp, w;
    logic [47:0] m;
    logic [15:0] tl, ul;
    logic [7:0]  prev_data;
    int          pidx, cyc, stray, hold_bad, acc_on_last, n;
    bit          done, saw_ir, prev_stall;

    tl = 16'(v.len + 28);
    ul = 16'(v.len + 8);
    for (int k = 0; k < 4; k++) begin
      if (k < v.len) begin
        tmp   = v.pl >> (8 * (v.len - 1 - k));
        pb[k] = tmp[7:0];
      end else begin
        pb[k] = 8'h00;
      end
    end

    m = DMAC;
    for (int i = 5; i >= 0; i--) exp_q.push_back(m[8*i +: 8]);
    m = SMAC;
    for (int i = 5; i >= 0; i--) exp_q.push_back(m[8*i +: 8]);
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    exp_q.push_back(8'h45); exp_q.push_back(8'h00);
    exp_q.push_back(tl[15:8]); exp_q.push_back(tl[7:0]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    exp_q.push_back(8'h40); exp_q.push_back(8'h11);
    exp_q.push_back(v.csum[15:8]); exp_q.push_back(v.csum[7:0]);
    w = SIP;
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    w = DIP;
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    exp_q.push_back(SPORT[15:8]); exp_q.push_back(SPORT[7:0]);
    exp_q.push_back(DPORT[15:8]); exp_q.push_back(DPORT[7:0]);
    exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int k = 0; k < v.len; k++) exp_q.push_back(pb[k]);

    request(v.len);

    pidx = 0; cyc = 0; stray = 0; hold_bad = 0; acc_on_last = 0;
    done = 0; saw_ir = 0; prev_stall = 0; prev_data = 8'h00;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      start_valid = 1'b0;
      out_ready   = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid    = (pidx < v.len) && (v.gap ? 1'($urandom_range(0, 1)) : 1'b1);
      in_data     = (pidx < v.len) ? pb[pidx] : 8'h00;
      #1;
      if (in_ready) saw_ir = 1;
      if (prev_stall && out_valid && out_data !== prev_data) hold_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (!v.stall && in_valid && !(out_valid && out_ready) && got_d.size() > 0) stray++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        if (out_last) begin
          done = 1;
          if (start_ready) acc_on_last++;
        end
      end
      if (in_valid && in_ready) pidx++;
      cyc++;
    end

    check("frame_done", done, 1);
    check("frame_bytes", got_d.size(), exp_q.size());
    n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("len%0d_byte%0d", v.len, i), got_d[i], exp_q[i]);
      check($sformatf("len%0d_last%0d", v.len, i), got_l[i], (i == exp_q.size() - 1));
    end
    if (got_d.size() >= 26) check("hdr_checksum", {got_d[24], got_d[25]}, v.csum);
    if (v.stall) check("stall_hold", hold_bad, 0);
    else         check("stray_gap", stray, 0);
    check("no_accept_on_last", acc_on_last, 0);
    check("payload_consumed", pidx, v.len);
    if (v.len == 0) check("in_ready_len0", saw_ir, 0);
  endtask

  initial begin
    int extra, ov, cnt, t;
    start_valid = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b1;
    set_cfg(0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_len_err", len_err, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_start_ready", start_ready, 0);
    reset = 1'b0;
    #1;
    check("start_ready_after_reset", start_ready, 1);

    vecs[0] = '{len: 4, pl: 32'hDEADBEEF, csum: 16'hB779, stall: 0, gap: 0};
    vecs[1] = '{len: 4, pl: 32'hDEADBEEF, csum: 16'hB779, stall: 1, gap: 0};
    vecs[2] = '{len: 0, pl: 32'h0,        csum: 16'hB77D, stall: 0, gap: 0};
    vecs[3] = '{len: 2, pl: 32'hA1A2,     csum: 16'hB77B, stall: 0, gap: 1};
    vecs[4] = '{len: 3, pl: 32'hB1B2B3,   csum: 16'hB77A, stall: 0, gap: 1};
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Oversize request is rejected with a single len_err pulse
    @(negedge clk);
    set_cfg(1473);
    start_valid = 1'b1;
    #1;
    check("start_ready_1473", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
    #1;
    check("len_err_pulse", len_err, 1);
    check("len_err_no_valid", out_valid, 0);
    extra = 0; ov = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (len_err) extra++;
      if (out_valid) ov++;
    end
    check("len_err_single", extra, 0);
    check("len_err_silent", ov, 0);
    check("len_err_idle", start_ready, 1);
    run_frame('{len: 1, pl: 32'h5A, csum: 16'hB77C, stall: 0, gap: 0});

    // Largest legal length is accepted; abort it with reset
    @(negedge clk);
    set_cfg(1472);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    #1;
    check("max_len_no_err", len_err, 0);
    check("max_len_header", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset while header byte 20 is on the output
    request(4);
    cnt = 0; t = 0;
    while (t < 200) begin
      @(negedge clk);
      start_valid = 1'b0;
      #1;
      if (cnt == 20) break;
      if (out_valid && out_ready) cnt++;
      t++;
    end
    check("reached_byte20", cnt, 20);
    check("byte20_value", out_data, 8'h40);
    reset = 1'b1;
    #1;
    check("midrst_no_last", out_last, 0);
    @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_no_last2", out_last, 0);
    check("midrst_start_ready", start_ready, 0);
    reset = 1'b0;
    #1;
    check("midrst_ready_after", start_ready, 1);
    check("midrst_valid_after", out_valid, 0);
    run_frame(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_packet_builder.md
UDP_PACKET_BUILDER -- requirements
Module: udp_packet_builder

Interface
REQ-001 SHALL have parameter IP_TTL, default 8'd64, TTL field value.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1472, largest legal payload in bytes.
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 src_mac/dst_mac  input  48 each  MAC addresses; SHALL be sampled on start accept.
REQ-006 src_ip/dst_ip  input  32 each  IPv4 addresses; SHALL be sampled on start accept.
REQ-007 src_port/dst_port  input  16 each  UDP ports; SHALL be sampled on start accept.
REQ-008 payload_len  input  11  payload byte count; SHALL be sampled on start accept.
REQ-009 start_valid  input  1 / start_ready  output  1  packet-request handshake.
REQ-010 in_data  input  8 / in_valid  input  1 / in_ready  output  1  payload byte stream.
REQ-011 out_data  output  8 / out_valid  output  1 / out_ready  input  1 / out_last  output  1  frame byte stream.
REQ-012 len_err  output  1  one-cycle pulse for a rejected request.

Function
REQ-013 States SHALL be IDLE, HEADER, PAYLOAD.
REQ-014 start_ready SHALL be 1 only in IDLE.
  - Accept = start_valid & start_ready.
REQ-015 An accept with payload_len > MAX_PAYLOAD SHALL pulse len_err for 1 cycle, remain in IDLE, and emit nothing.
REQ-016 A legal accept SHALL latch all config inputs and enter HEADER on the next cycle.
REQ-017 HEADER SHALL emit 42 bytes MSB-first in this order:
  - dst_mac, src_mac, 08 00
  - 45 00, total_len, 00 00 (ID), 40 00 (DF), IP_TTL, 11
  - hdr_checksum, src_ip, dst_ip
  - src_port, dst_port, udp_len, 00 00 (UDP checksum)
REQ-018 total_len SHALL equal payload_len+28 and udp_len SHALL equal payload_len+8, both 16-bit zero-extended.
REQ-019 hdr_checksum SHALL be the ones-complement of the end-around-carry 16-bit sum of the nine IP header words, excluding the checksum word.
REQ-020 The checksum SHALL be computed serially, one word per cycle starting at accept, with a 20-bit accumulator and a final fold.
  - It SHALL be complete before header byte 24 is presented.
  - Output stalls SHALL NOT corrupt it.
REQ-021 A header byte SHALL advance only on out_valid & out_ready.
  - out_valid SHALL be 1 throughout HEADER.
  - out_data SHALL be held stable while stalled.
REQ-022 in_ready SHALL be 0 in IDLE and HEADER.
REQ-023 In PAYLOAD the datapath SHALL be a combinational pass-through with zero latency:
  - out_valid = in_valid
  - out_data = in_data
  - in_ready = out_ready
REQ-024 A payload counter (11 bits) SHALL decrement on each payload transfer.
  - out_last SHALL be 1 on the byte where the counter equals 1.
  - That transfer SHALL return the block to IDLE.
REQ-025 With payload_len = 0, out_last SHALL be 1 on header byte 41 (the final UDP checksum byte), and PAYLOAD SHALL be skipped.
REQ-026 The header byte index (6 bits) SHALL reset to 0 on entering HEADER.
  - Transition to PAYLOAD SHALL occur on the transfer of byte 41.
REQ-027 out_last SHALL be 0 on every byte other than the final byte of the frame.
REQ-028 A new start SHALL NOT be accepted in the cycle the final byte transfers.
  - The earliest next accept is the following cycle.
REQ-029 Back-to-back requests SHALL produce frames with no shared or dropped bytes.
REQ-030 Outside PAYLOAD, in_valid SHALL be ignored and no payload byte consumed.

Reset
REQ-031 Reset SHALL force the following values:
  - state IDLE
  - out_valid, out_last, in_ready, len_err = 0
  - out_data = 8'h00, start_ready = 0 during reset
  - counters and checksum accumulator = 0
REQ-032 Reset mid-frame SHALL abort the frame immediately with no out_last.
  - start_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 Bench SHALL cover these scenarios:
  - Golden 4-byte frame: len=4, src_ip C0A80101, dst_ip C0A80102, TTL 64, payload DE AD BE EF, out_ready=1 -> 46 bytes, total_len 0020, udp_len 000C, checksum B779, out_last on EF.
  - Random out_ready backpressure (50%) on the same frame -> byte sequence identical to the no-stall case, checksum still B779.
  - len=0 -> exactly 42 bytes, out_last on byte 41, in_ready never 1.
  - len=1473 -> len_err single pulse, no out_valid, next legal request served normally.
  - Reset asserted at header byte 20 -> out_valid 0 next cycle, no out_last, clean frame on the following request.
  - Two back-to-back requests (len 2, len 3) with in_valid gapped -> 44 then 45 bytes, each with one out_last, no gap beyond input gaps.
